ili9341_bus_rx: RTL and testbench

ILI9341_BUS_RX -- requirements
Module: ili9341_bus_rx

---
 rtl/ili9341_pkg.sv | 31 +++
 rtl/ili9341_bus_sampler.sv | 26 ++
 rtl/ili9341_bus_rx.sv | 179 +++++++++++++++++
 tb/tb_ili9341_bus_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// Shared opcodes, FSM states and window defaults
// for the ILI9341 parallel-bus receiver.
package ili9341_pkg;

  localparam logic [7:0] OP_SLPIN  = 8'h10;
  localparam logic [7:0] OP_SLPOUT = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON = 8'h29;
  localparam logic [7:0] OP_CASET  = 8'h2A;
  localparam logic [7:0] OP_PASET  = 8'h2B;
  localparam logic [7:0] OP_RAMWR  = 8'h2C;
  localparam logic [7:0] OP_MADCTL = 8'h36;
  localparam logic [7:0] OP_COLMOD = 8'h3A;
  localparam logic [7:0] OP_RAMWRC = 8'h3C;

  localparam int DEF_COLS = 240;
  localparam int DEF_ROWS = 320;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_RAMWR_HI,
    S_RAMWR_LO,
    S_DISCARD
  } state_t;

  function automatic logic [15:0] win_end(input int n);
    return 16'(n - 1);
  endfunction

endpackage

// File: rtl/ili9341_bus_sampler.sv
// Strobe edge detector: flags the clock where wr is
// high after being sampled low; byte/rs pass through.
module ili9341_bus_sampler (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_lcd_data,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_wr,
  output logic [7:0] o_byte,
  output logic       o_rs,
  output logic       o_strobe
);

  logic r_wr_q;

  // Reset to 1 so a bus idling high cannot fake an edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_wr_q <= 1'b1;
    else         r_wr_q <= i_lcd_wr;
  end

  assign o_strobe = i_lcd_wr & ~r_wr_q;
  assign o_byte   = i_lcd_data;
  assign o_rs     = i_lcd_rs;

endmodule

// File: rtl/ili9341_bus_rx.sv
// ILI9341 8080 bus receiver: decodes commands and
// turns RAMWR byte pairs into framebuffer writes.
module ili9341_bus_rx
  import ili9341_pkg::*;
#(
  parameter int P_COLS = DEF_COLS,
  parameter int P_ROWS = DEF_ROWS
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_lcd_data,
  input  logic        i_lcd_rs,
  input  logic        i_lcd_wr,
  output logic        o_pix_valid,
  output logic [8:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic [15:0] o_pix_data,
  output logic [7:0]  o_madctl,
  output logic [7:0]  o_colmod,
  output logic        o_display_on,
  output logic        o_sleep_out
);

  localparam logic [15:0] L_COLS = 16'(P_COLS);
  localparam logic [15:0] L_ROWS = 16'(P_ROWS);

  logic [7:0] w_byte;
  logic       w_rs;
  logic       w_stb;

  ili9341_bus_sampler u_smp (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_lcd_data (i_lcd_data),
    .i_lcd_rs   (i_lcd_rs),
    .i_lcd_wr   (i_lcd_wr),
    .o_byte     (w_byte),
    .o_rs       (w_rs),
    .o_strobe   (w_stb)
  );

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cmd;
  logic [1:0]  r_pcnt;
  logic [7:0]  r_p0;
  logic [7:0]  r_p1;
  logic [7:0]  r_p2;
  logic [15:0] r_cs;
  logic [15:0] r_ce;
  logic [15:0] r_ps;
  logic [15:0] r_pe;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [7:0]  r_hi;

  logic w_cmd_ev;
  logic w_dat_ev;
  logic w_win_ok;
  logic w_in_panel;

  assign w_cmd_ev   = w_stb & ~w_rs;
  assign w_dat_ev   = w_stb & w_rs;
  assign w_win_ok   = (r_cs <= r_ce) && (r_ps <= r_pe);
  assign w_in_panel = (r_x < L_COLS) && (r_y < L_ROWS);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cmd_ev) begin
      case (w_byte)
        OP_CASET, OP_PASET,
        OP_MADCTL, OP_COLMOD: w_state_nxt = S_PARAM;
        OP_RAMWR, OP_RAMWRC:  w_state_nxt = S_RAMWR_HI;
        default:              w_state_nxt = S_DISCARD;
      endcase
    end else if (w_dat_ev) begin
      case (r_state)
        S_PARAM: begin
          if (r_cmd == OP_MADCTL || r_cmd == OP_COLMOD)
            w_state_nxt = S_DISCARD;
          else if (r_pcnt == 2'd3)
            w_state_nxt = S_IDLE;
        end
        S_RAMWR_HI: w_state_nxt = S_RAMWR_LO;
        S_RAMWR_LO: w_state_nxt = S_RAMWR_HI;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd        <= 8'h00;
      r_pcnt       <= 2'd0;
      r_p0         <= 8'h00;
      r_p1         <= 8'h00;
      r_p2         <= 8'h00;
      r_cs         <= 16'd0;
      r_ce         <= win_end(P_COLS);
      r_ps         <= 16'd0;
      r_pe         <= win_end(P_ROWS);
      r_x          <= 16'd0;
      r_y          <= 16'd0;
      r_hi         <= 8'h00;
      o_pix_valid  <= 1'b0;
      o_pix_x      <= 9'd0;
      o_pix_y      <= 9'd0;
      o_pix_data   <= 16'h0000;
      o_madctl     <= 8'h00;
      o_colmod     <= 8'h00;
      o_display_on <= 1'b0;
      o_sleep_out  <= 1'b0;
    end else begin
      o_pix_valid <= 1'b0;
      if (w_cmd_ev) begin
        r_cmd  <= w_byte;
        r_pcnt <= 2'd0;
        case (w_byte)
          OP_SLPIN:   o_sleep_out  <= 1'b0;
          OP_SLPOUT:  o_sleep_out  <= 1'b1;
          OP_DISPOFF: o_display_on <= 1'b0;
          OP_DISPON:  o_display_on <= 1'b1;
          OP_RAMWR: begin
            r_x <= r_cs;
            r_y <= r_ps;
          end
          default: ;
        endcase
      end else if (w_dat_ev) begin
        case (r_state)
          S_PARAM: begin
            r_pcnt <= r_pcnt + 2'd1;
            case (r_pcnt)
              2'd0:    r_p0 <= w_byte;
              2'd1:    r_p1 <= w_byte;
              2'd2:    r_p2 <= w_byte;
              default: ;
            endcase
            if (r_cmd == OP_MADCTL) o_madctl <= w_byte;
            if (r_cmd == OP_COLMOD) o_colmod <= w_byte;
            if (r_pcnt == 2'd3 && r_cmd == OP_CASET) begin
              r_cs <= {r_p0, r_p1};
              r_ce <= {r_p2, w_byte};
            end
            if (r_pcnt == 2'd3 && r_cmd == OP_PASET) begin
              r_ps <= {r_p0, r_p1};
              r_pe <= {r_p2, w_byte};
            end
          end
          S_RAMWR_HI: r_hi <= w_byte;
          S_RAMWR_LO: begin
            // An inverted window freezes the address entirely.
            if (w_win_ok) begin
              if (w_in_panel) begin
                o_pix_valid <= 1'b1;
                o_pix_x     <= r_x[8:0];
                o_pix_y     <= r_y[8:0];
                o_pix_data  <= {r_hi, w_byte};
              end
              if (r_x == r_ce) begin
                r_x <= r_cs;
                r_y <= (r_y == r_pe) ? r_ps : r_y + 16'd1;
              end else begin
                r_x <= r_x + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ili9341_bus_rx.sv
// Bench for ili9341_bus_rx: directed bus sequences plus
// random windows, checked against a byte-level model.
module tb_ili9341_bus_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  lcd_data = 8'h00;
  logic        lcd_rs = 1'b0;
  logic        lcd_wr = 1'b0;
  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic [7:0]  madctl;
  logic [7:0]  colmod;
  logic        disp_on;
  logic        sleep_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ili9341_bus_rx dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_lcd_data   (lcd_data),
    .i_lcd_rs     (lcd_rs),
    .i_lcd_wr     (lcd_wr),
    .o_pix_valid  (pix_valid),
    .o_pix_x      (pix_x),
    .o_pix_y      (pix_y),
    .o_pix_data   (pix_data),
    .o_madctl     (madctl),
    .o_colmod     (colmod),
    .o_display_on (disp_on),
    .o_sleep_out  (sleep_out)
  );

  logic [33:0] obs[$];
  logic [33:0] exp_q[$];

  always @(negedge clk)
    if (pix_valid) obs.push_back({pix_x, pix_y, pix_data});

  // Reference model state
  int m_mode;
  int m_cmd;
  int m_par[$];
  int m_cs, m_ce, m_ps, m_pe, m_x, m_y;
  int m_hi;
  int m_madctl, m_colmod, m_disp, m_sleep;

  task automatic m_reset();
    m_mode = 0; m_cmd = 0; m_par.delete();
    m_cs = 0; m_ce = 239; m_ps = 0; m_pe = 319;
    m_x = 0; m_y = 0; m_hi = 0;
    m_madctl = 0; m_colmod = 0; m_disp = 0; m_sleep = 0;
  endtask

  task automatic m_write(input bit rs, input int b);
    logic [15:0] pix;
    if (!rs) begin
      m_par.delete();
      m_cmd = b;
      m_mode = 0;
      case (b)
        'h2A, 'h2B, 'h36, 'h3A: m_mode = 1;
        'h2C: begin m_x = m_cs; m_y = m_ps; m_mode = 2; end
        'h3C: m_mode = 2;
        'h11: m_sleep = 1;
        'h10: m_sleep = 0;
        'h29: m_disp = 1;
        'h28: m_disp = 0;
        default: ;
      endcase
    end else if (m_mode == 1) begin
      m_par.push_back(b);
      if (m_cmd == 'h36) begin m_madctl = b; m_mode = 0; end
      else if (m_cmd == 'h3A) begin m_colmod = b; m_mode = 0; end
      else if (m_par.size() == 4) begin
        if (m_cmd == 'h2A) begin
          m_cs = m_par[0] * 256 + m_par[1];
          m_ce = m_par[2] * 256 + m_par[3];
        end else begin
          m_ps = m_par[0] * 256 + m_par[1];
          m_pe = m_par[2] * 256 + m_par[3];
        end
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      m_hi = b;
      m_mode = 3;
    end else if (m_mode == 3) begin
      m_mode = 2;
      pix = 16'(m_hi * 256 + b);
      if (m_cs <= m_ce && m_ps <= m_pe) begin
        if (m_x < 240 && m_y < 320)
          exp_q.push_back({9'(m_x), 9'(m_y), pix});
        if (m_x == m_ce) begin
          m_x = m_cs;
          m_y = (m_y == m_pe) ? m_ps : (m_y + 1) % 65536;
        end else begin
          m_x = (m_x + 1) % 65536;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [33:0] o,
                     input logic [33:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic send(input bit rs, input int b);
    @(negedge clk);
    lcd_wr = 1'b0;
    lcd_rs = rs;
    lcd_data = 8'(b);
    @(negedge clk);
    lcd_wr = 1'b1;
    @(negedge clk);
    m_write(rs, b);
  endtask

  task automatic cmd(input int b); send(1'b0, b); endtask
  task automatic par(input int b); send(1'b1, b); endtask

  task automatic pixel(input int d);
    par((d >> 8) & 'hFF);
    par(d & 'hFF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic flush(input string tag);
    int n;
    repeat (4) @(negedge clk);
    chk({tag, "_cnt"}, 34'(obs.size()), 34'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_pix"}, obs[i], exp_q[i]);
    chk({tag, "_madctl"}, 34'(madctl), 34'(m_madctl));
    chk({tag, "_colmod"}, 34'(colmod), 34'(m_colmod));
    chk({tag, "_disp"}, 34'(disp_on), 34'(m_disp));
    chk({tag, "_sleep"}, 34'(sleep_out), 34'(m_sleep));
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cs, ce, ps, pe, n;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 34'(pix_valid), 34'd0);
    chk("rst_xy", {pix_x, pix_y, pix_data}, 34'd0);
    chk("rst_madctl", 34'(madctl), 34'd0);
    chk("rst_colmod", 34'(colmod), 34'd0);
    chk("rst_flags", {32'd0, disp_on, sleep_out}, 34'd0);

    cmd('h2A); par(0); par(0); par(0); par('hEF);
    cmd('h2B); par(0); par(0); par(1); par('h3F);
    cmd('h2C); par('hF8); par('h00);
    repeat (4) @(negedge clk);
    chk("first_pix", obs[0], {9'd0, 9'd0, 16'hF800});
    chk("hold_data", 34'(pix_data), 34'h0F800);
    flush("first");

    cmd('h2A); par(0); par('h0A); par(0); par('h0B);
    cmd('h2B); par(0); par(5); par(0); par(6);
    cmd('h2C);
    for (int i = 0; i < 5; i++) pixel(i + 'h100);
    repeat (4) @(negedge clk);
    chk("wrap_last", obs[4], {9'd10, 9'd5, 16'h0104});
    flush("wrap");

    cmd('h2C); par('hAA); cmd('h3C); par('h12); par('h34);
    repeat (4) @(negedge clk);
    chk("abort_data", obs[0], {9'd10, 9'd5, 16'h1234});
    flush("abort");

    cmd('h29); cmd('h11);
    cmd('h3A); par('h55);
    cmd('h36); par('h48);
    cmd('hEF); par(3); par('h80);
    repeat (4) @(negedge clk);
    chk("regs", {10'd0, disp_on, sleep_out, madctl, colmod, 8'd0},
        {10'd0, 1'b1, 1'b1, 8'h48, 8'h55, 8'd0});
    flush("cmds");

    cmd('h2A); par(0); par('hF0); par(0); par('hF1);
    cmd('h2C); pixel('h1111); pixel('h2222);
    cmd('h2A); par(0); par(5); par(0); par(2);
    cmd('h2C); pixel('h3333);
    flush("suppress");

    cmd('h2A); par(0); par(1);
    do_reset();
    cmd('h2C); pixel('hBEEF);
    repeat (4) @(negedge clk);
    chk("reset_mid", obs[0], {9'd0, 9'd0, 16'hBEEF});
    flush("reset_mid");

    for (int it = 0; it < 20; it++) begin
      cs = $urandom_range(0, 245);
      ce = ($urandom_range(0, 7) == 0) ? cs - 1 : cs + $urandom_range(0, 3);
      ps = $urandom_range(0, 323);
      pe = ps + $urandom_range(0, 2);
      if (ce < 0) ce = 0;
      cmd('h2A); par(cs >> 8); par(cs & 'hFF); par(ce >> 8); par(ce & 'hFF);
      cmd('h2B); par(ps >> 8); par(ps & 'hFF); par(pe >> 8); par(pe & 'hFF);
      cmd($urandom_range(0, 1) ? 'h2C : 'h3C);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) pixel($urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) begin
        par($urandom_range(0, 255));
        cmd('h3C);
        pixel($urandom_range(0, 65535));
      end
      if ($urandom_range(0, 3) == 0) begin
        cmd($urandom_range(0, 1) ? 'h36 : 'h3A);
        par($urandom_range(0, 255));
        par($urandom_range(0, 255));
      end
      flush("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
